direction_control_multi: RTL and testbench

//  Parametrised successor of the per-player heading register for the Tron/snake game.
//  - Drives N_PLAYERS independent heading registers from one mouse (left/right buttons).
//  - Button presses are edge-detected and held as one-deep pending turns.
//  - Pending turns are applied on a periodic game tick, which is also exported to the movement logic.
//  - Sits between the mouse decoder/player-select logic and the per-player position/drawing blocks.

---
 rtl/game_pkg.sv | 35 +++
 rtl/direction_control_multi_if.sv | 24 ++
 rtl/mouse_btn_edge.sv | 18 +
 rtl/direction_control_multi.sv | 100 ++++++++++
 tb/tb_direction_control_multi.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game types: player headings, turn tables and tick defaults.
package game_pkg;

    typedef enum logic [2:0] {WAIT, RIGHT, DOWN, LEFT, UP} directions;

    localparam int unsigned DEFAULT_TICK_CYCLES = 8_125_000;

    // Right-button turn; an unknown encoding falls back to WAIT.
    function automatic directions turn_cw(directions d);
        case (d)
            WAIT:    return RIGHT;
            RIGHT:   return DOWN;
            DOWN:    return LEFT;
            LEFT:    return UP;
            UP:      return RIGHT;
            default: return WAIT;
        endcase
    endfunction

    function automatic directions turn_ccw(directions d);
        case (d)
            WAIT:    return LEFT;
            RIGHT:   return UP;
            DOWN:    return RIGHT;
            LEFT:    return DOWN;
            UP:      return LEFT;
            default: return WAIT;
        endcase
    endfunction

    function automatic int unsigned sel_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/direction_control_multi_if.sv
// Mouse-side inputs and per-player heading outputs of the direction controller.
interface direction_control_multi_if #(
    parameter int unsigned N_PLAYERS = 2
);
    localparam int unsigned SEL_W = game_pkg::sel_width(N_PLAYERS);

    logic                 game_en;
    logic [SEL_W-1:0]     player_sel;
    logic                 mouse_left;
    logic                 mouse_right;
    game_pkg::directions  direction [N_PLAYERS];
    logic                 tick;
    logic                 turn_drop;

    modport master (
        output game_en, player_sel, mouse_left, mouse_right,
        input  direction, tick, turn_drop
    );

    modport slave (
        input  game_en, player_sel, mouse_left, mouse_right,
        output direction, tick, turn_drop
    );
endinterface

// File: rtl/mouse_btn_edge.sv
// Rising-edge detector for a level mouse button; one flop of history.
module mouse_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    logic btn_q, btn_d;

    always_comb btn_d = btn;

    always_ff @(posedge clk) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn_d;
    end

    assign press = btn & ~btn_q;
endmodule

// File: rtl/direction_control_multi.sv
// Per-player heading registers driven from one mouse; turns are queued one deep
// and applied on a periodic game tick.
module direction_control_multi
    import game_pkg::*;
#(
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned TICK_CYCLES = DEFAULT_TICK_CYCLES
) (
    input logic                      clk,
    input logic                      rst,
    direction_control_multi_if.slave bus
);
    localparam int unsigned     CNT_W   = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_CYCLES - 1);

    logic press_l, press_r;

    mouse_btn_edge u_edge_l (.clk(clk), .rst(rst), .btn(bus.mouse_left),  .press(press_l));
    mouse_btn_edge u_edge_r (.clk(clk), .rst(rst), .btn(bus.mouse_right), .press(press_r));

    logic [CNT_W-1:0]     count_q, count_d;
    logic                 tick_q, tick_d;
    logic                 turn_drop_q, turn_drop_d;
    logic [N_PLAYERS-1:0] pend_vld_q, pend_vld_d;
    logic [N_PLAYERS-1:0] pend_turn_q, pend_turn_d;
    directions            dir_q [N_PLAYERS];
    directions            dir_d [N_PLAYERS];
    logic                 sel_ok;

    always_comb begin
        count_d = '0;
        tick_d  = 1'b0;
        if (bus.game_en) begin
            if (count_q == CNT_MAX) tick_d = 1'b1;
            else                    count_d = count_q + 1'b1;
        end
    end

    always_comb begin
        sel_ok      = 32'(bus.player_sel) < N_PLAYERS;
        turn_drop_d = 1'b0;
        pend_vld_d  = pend_vld_q;
        pend_turn_d = pend_turn_q;
        dir_d       = dir_q;

        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            if (tick_d && pend_vld_q[p]) begin
                dir_d[p]      = pend_turn_q[p] ? turn_cw(dir_q[p]) : turn_ccw(dir_q[p]);
                pend_vld_d[p] = 1'b0;
            end
        end

        // Checking pend_vld_d lets a press on the apply edge queue for the next tick.
        if (press_l || press_r) begin
            if ((press_l && press_r) || !sel_ok) begin
                turn_drop_d = 1'b1;
            end else begin
                for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                    if (32'(bus.player_sel) == p) begin
                        if (pend_vld_d[p]) begin
                            turn_drop_d = 1'b1;
                        end else begin
                            pend_vld_d[p]  = 1'b1;
                            pend_turn_d[p] = press_r;
                        end
                    end
                end
            end
        end

        if (!bus.game_en) begin
            turn_drop_d = 1'b0;
            pend_vld_d  = '0;
            pend_turn_d = '0;
            for (int unsigned p = 0; p < N_PLAYERS; p++) dir_d[p] = WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            tick_q      <= 1'b0;
            turn_drop_q <= 1'b0;
            pend_vld_q  <= '0;
            pend_turn_q <= '0;
            dir_q       <= '{default: WAIT};
        end else begin
            count_q     <= count_d;
            tick_q      <= tick_d;
            turn_drop_q <= turn_drop_d;
            pend_vld_q  <= pend_vld_d;
            pend_turn_q <= pend_turn_d;
            dir_q       <= dir_d;
        end
    end

    assign bus.direction = dir_q;
    assign bus.tick      = tick_q;
    assign bus.turn_drop = turn_drop_q;
endmodule

// File: tb/tb_direction_control_multi.sv
// Scoreboard bench: expected headings per tick and expected drop cycles are queued
// by the stimulus and consumed by a monitor whenever tick or turn_drop fires.
module tb_direction_control_multi;
    import game_pkg::*;

    localparam int unsigned TICK = 4;

    typedef struct packed {
        directions d0;
        directions d1;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_tick = 0;
    bit   en_gap = 1'b1;
    exp_t exp_q [$];
    int   drop_q [$];
    exp_t mon_e;

    direction_control_multi_if #(.N_PLAYERS(2)) bus ();
    direction_control_multi_if #(.N_PLAYERS(3)) bus3 ();

    direction_control_multi #(.N_PLAYERS(2), .TICK_CYCLES(TICK)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    direction_control_multi #(.N_PLAYERS(3), .TICK_CYCLES(TICK)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not expected / not seen (cycle %0d)", name, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sync_tick();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.tick) got = 1'b1;
        end
        if (!got) fail_now("tick_timeout");
    endtask

    // Align to a tick, then queue the headings expected at the tick closing this period.
    task automatic period(input directions e0, input directions e1);
        sync_tick();
        step();
        exp_q.push_back('{d0: e0, d1: e1});
    endtask

    task automatic pulse_r();
        bus.mouse_right = 1'b1;
        step();
        bus.mouse_right = 1'b0;
    endtask

    task automatic pulse_l();
        bus.mouse_left = 1'b1;
        step();
        bus.mouse_left = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tick) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_tick");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tick_dir0", int'(bus.direction[0]), int'(mon_e.d0));
                    check("tick_dir1", int'(bus.direction[1]), int'(mon_e.d1));
                end
                if (!en_gap) check("tick_period", cyc - last_tick, TICK);
                en_gap    = 1'b0;
                last_tick = cyc;
            end
            if (bus.turn_drop) begin
                if (drop_q.size() == 0) fail_now("unexpected_drop");
                else                    check("drop_cycle", cyc, drop_q.pop_front());
            end
        end
    end

    initial begin
        directions seq [5];
        int  k;
        bit  found;
        seq = '{RIGHT, DOWN, LEFT, UP, RIGHT};

        bus.game_en = 1'b1;  bus.player_sel = '0;  bus.mouse_left = 1'b0;  bus.mouse_right = 1'b0;
        bus3.game_en = 1'b0; bus3.player_sel = '0; bus3.mouse_left = 1'b0; bus3.mouse_right = 1'b0;
        repeat (3) step();

        check("rst_dir0", int'(bus.direction[0]), int'(WAIT));
        check("rst_dir1", int'(bus.direction[1]), int'(WAIT));
        check("rst_tick", int'(bus.tick), 0);
        check("rst_drop", int'(bus.turn_drop), 0);
        check("rst_n3_dir2", int'(bus3.direction[2]), int'(WAIT));

        // Idle run: ticks every TICK cycles, headings stay WAIT.
        exp_q.push_back('{d0: WAIT, d1: WAIT});
        rst = 1'b0;
        repeat (5) period(WAIT, WAIT);

        // Player 0 turns right once per tick through the full cycle.
        bus.player_sel = 1'd0;
        for (int i = 0; i < 5; i++) begin
            period(seq[i], WAIT);
            pulse_r();
        end

        // Player 1 holds right for 12 cycles: exactly one turn.
        period(RIGHT, RIGHT);
        bus.player_sel  = 1'd1;
        bus.mouse_right = 1'b1;
        period(RIGHT, RIGHT);
        period(RIGHT, RIGHT);
        period(RIGHT, RIGHT);
        bus.mouse_right = 1'b0;

        // Second press while pending is dropped; first request kept.
        period(RIGHT, DOWN);
        pulse_r();
        drop_q.push_back(cyc + 1);
        pulse_l();

        // Both buttons on one cycle: dropped, no change.
        period(RIGHT, DOWN);
        bus.mouse_left  = 1'b1;
        bus.mouse_right = 1'b1;
        drop_q.push_back(cyc + 1);
        step();
        bus.mouse_left  = 1'b0;
        bus.mouse_right = 1'b0;

        // Press on the apply edge becomes the next tick's request, not a drop.
        period(RIGHT, LEFT);
        pulse_r();
        step();
        pulse_r();
        period(RIGHT, UP);

        // Two players turn on the same tick.
        period(DOWN, LEFT);
        bus.player_sel = 1'd0;
        pulse_r();
        bus.player_sel = 1'd1;
        pulse_l();

        // Disable mid-period with a pending turn.
        sync_tick();
        step();
        bus.player_sel = 1'd0;
        pulse_r();
        bus.game_en = 1'b0;
        en_gap      = 1'b1;
        step();
        check("dis_dir0", int'(bus.direction[0]), int'(WAIT));
        check("dis_dir1", int'(bus.direction[1]), int'(WAIT));
        step();
        check("dis_no_tick", int'(bus.tick), 0);
        pulse_l();
        repeat (3) step();

        exp_q.push_back('{d0: WAIT, d1: WAIT});
        bus.game_en = 1'b1;
        k     = 0;
        found = 1'b0;
        repeat (8) begin
            if (!found) begin
                @(posedge clk);
                k++;
                @(negedge clk);
                if (bus.tick) found = 1'b1;
            end
        end
        check("reenable_latency", k, TICK);
        step();
        bus.game_en = 1'b0;

        // Three-player instance: out-of-range select drops, player 2 turns.
        bus3.game_en     = 1'b1;
        bus3.player_sel  = 2'd3;
        bus3.mouse_right = 1'b1;
        step();
        bus3.mouse_right = 1'b0;
        check("n3_sel_oob_drop", int'(bus3.turn_drop), 1);
        step();
        check("n3_drop_one_cycle", int'(bus3.turn_drop), 0);
        bus3.player_sel  = 2'd2;
        bus3.mouse_right = 1'b1;
        step();
        bus3.mouse_right = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus3.tick) found = 1'b1;
        end
        if (!found) fail_now("n3_tick_timeout");
        check("n3_dir0", int'(bus3.direction[0]), int'(WAIT));
        check("n3_dir1", int'(bus3.direction[1]), int'(WAIT));
        check("n3_dir2", int'(bus3.direction[2]), int'(RIGHT));
        step();
        bus3.game_en = 1'b0;
        repeat (2) step();

        check("ticks_outstanding", exp_q.size(), 0);
        check("drops_outstanding", drop_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
